// File: rtl/card_pkg.sv
// Card codes, 7-segment glyphs and FSM state type shared by the card display bank.
package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [6:0] glyph_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TWO   = 4'd2;
  localparam card_t CARD_THREE = 4'd3;
  localparam card_t CARD_FOUR  = 4'd4;
  localparam card_t CARD_FIVE  = 4'd5;
  localparam card_t CARD_SIX   = 4'd6;
  localparam card_t CARD_SEVEN = 4'd7;
  localparam card_t CARD_EIGHT = 4'd8;
  localparam card_t CARD_NINE  = 4'd9;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_JACK  = 4'd11;
  localparam card_t CARD_QUEEN = 4'd12;
  localparam card_t CARD_KING  = 4'd13;

  // Active-low segments, bit6 = g ... bit0 = a.
  localparam glyph_t GLYPH_EMPTY = 7'b1111111;
  localparam glyph_t GLYPH_ACE   = 7'b0001000;
  localparam glyph_t GLYPH_TWO   = 7'b0100100;
  localparam glyph_t GLYPH_THREE = 7'b0110000;
  localparam glyph_t GLYPH_FOUR  = 7'b0011001;
  localparam glyph_t GLYPH_FIVE  = 7'b0010010;
  localparam glyph_t GLYPH_SIX   = 7'b0000010;
  localparam glyph_t GLYPH_SEVEN = 7'b1111000;
  localparam glyph_t GLYPH_EIGHT = 7'b0000000;
  localparam glyph_t GLYPH_NINE  = 7'b0010000;
  localparam glyph_t GLYPH_TEN   = 7'b1000000;
  localparam glyph_t GLYPH_JACK  = 7'b1100001;
  localparam glyph_t GLYPH_QUEEN = 7'b0011000;
  localparam glyph_t GLYPH_KING  = 7'b0001001;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } bank_state_t;

  // Card code to glyph; codes 0, 14 and 15 render blank.
  function automatic glyph_t card_glyph(input card_t card);
    glyph_t g;
    case (card)
      CARD_ACE:   g = GLYPH_ACE;
      CARD_TWO:   g = GLYPH_TWO;
      CARD_THREE: g = GLYPH_THREE;
      CARD_FOUR:  g = GLYPH_FOUR;
      CARD_FIVE:  g = GLYPH_FIVE;
      CARD_SIX:   g = GLYPH_SIX;
      CARD_SEVEN: g = GLYPH_SEVEN;
      CARD_EIGHT: g = GLYPH_EIGHT;
      CARD_NINE:  g = GLYPH_NINE;
      CARD_TEN:   g = GLYPH_TEN;
      CARD_JACK:  g = GLYPH_JACK;
      CARD_QUEEN: g = GLYPH_QUEEN;
      CARD_KING:  g = GLYPH_KING;
      default:    g = GLYPH_EMPTY;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/card_blink_timer.sv
// Reveal animation timer: cnt runs 0..BLINK_HALF-1 per phase, phase runs 0..BLINK_PHASES-1.
module card_blink_timer #(
  parameter int unsigned BLINK_HALF   = 4,
  parameter int unsigned BLINK_PHASES = 4,
  localparam int unsigned CNT_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1,
  localparam int unsigned PHASE_W = $clog2(BLINK_PHASES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  input  logic en,
  output logic show_c,
  output logic done_c
);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BLINK_HALF - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_PHASES - 1);

  logic [CNT_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  logic               wrap_c;

  assign wrap_c = (cnt == CNT_LAST);
  assign done_c = en && wrap_c && (phase == PHASE_LAST);
  // Even phases hide the card, odd phases show it; phase 0 is OFF.
  assign show_c = phase[0];

  // Counters restart on start/clear and park at zero once the reveal completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= '0;
    end else if (clear || start || done_c) begin
      cnt   <= '0;
      phase <= '0;
    end else if (en) begin
      if (wrap_c) begin
        cnt   <= '0;
        phase <= phase + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/card_hex_bank.sv
// Multi-slot card display bank: slot storage, load handshake, reveal blink and glyph decode.
module card_hex_bank #(
  parameter int unsigned NUM_SLOTS    = 6,
  parameter int unsigned BLINK_HALF   = 4,
  parameter int unsigned BLINK_PHASES = 4,
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load_valid,
  input  logic [SLOT_W-1:0]      load_slot,
  input  logic [3:0]             load_card,
  output logic                   load_ready,
  output logic                   busy,
  output logic [NUM_SLOTS*7-1:0] hex_out
);

  import card_pkg::*;

  localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);

  bank_state_t         state_q;
  bank_state_t         state_d;
  card_t               slot_q [NUM_SLOTS];
  logic [SLOT_W-1:0]   blink_slot;
  logic                accept_c;
  logic                in_range_c;
  logic                start_c;
  logic                show_c;
  logic                done_c;

  assign load_ready = (state_q == IDLE);
  assign busy       = ~load_ready;
  assign accept_c   = load_valid && load_ready && !clear;
  assign in_range_c = ({1'b0, load_slot} < SLOT_LIMIT);

  // Blink phase/cycle counters for the slot being revealed.
  card_blink_timer #(
    .BLINK_HALF   (BLINK_HALF),
    .BLINK_PHASES (BLINK_PHASES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .start  (start_c),
    .en     (busy),
    .show_c (show_c),
    .done_c (done_c)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; out-of-range loads are consumed without leaving IDLE.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c && in_range_c) begin
          state_d = BLINK;
          start_c = 1'b1;
        end
      end
      BLINK: begin
        if (done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      start_c = 1'b0;
    end
  end

  // Remember which slot is blinking for the duration of the reveal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_slot <= '0;
    end else if (clear) begin
      blink_slot <= '0;
    end else if (accept_c && in_range_c) begin
      blink_slot <= load_slot;
    end
  end

  // Slot register file: clear wipes every slot, an accepted in-range load writes one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= CARD_EMPTY;
      end
    end else if (clear) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= CARD_EMPTY;
      end
    end else if (accept_c && in_range_c) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (load_slot == SLOT_W'(i)) begin
          slot_q[i] <= load_card;
        end
      end
    end
  end

  // Glyph decode from registered state; the revealing slot is blanked in even phases.
  always_comb begin
    hex_out = '1;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (busy && (blink_slot == SLOT_W'(i)) && !show_c) begin
        hex_out[7*i +: 7] = GLYPH_EMPTY;
      end else begin
        hex_out[7*i +: 7] = card_glyph(slot_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_card_hex_bank.sv
// Directed bench for card_hex_bank with default parameters (6 slots, 4x4 blink).
module tb_card_hex_bank;

  localparam logic [6:0]  E       = 7'b1111111;
  localparam logic [41:0] ALL_OFF = {42{1'b1}};

  typedef struct {
    logic [3:0] card;
    logic [6:0] glyph;
  } glyph_vec_t;

  typedef struct {
    logic [2:0] slot;
    logic [3:0] card;
    logic [6:0] glyph;
  } fill_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        load_valid;
  logic [2:0]  load_slot;
  logic [3:0]  load_card;
  logic        load_ready;
  logic        busy;
  logic [41:0] hex_out;

  int n_chk  = 0;
  int n_fail = 0;

  glyph_vec_t gv [16];
  fill_vec_t  fv [6];

  card_hex_bank #(
    .NUM_SLOTS    (6),
    .BLINK_HALF   (4),
    .BLINK_PHASES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .load_valid (load_valid),
    .load_slot  (load_slot),
    .load_card  (load_card),
    .load_ready (load_ready),
    .busy       (busy),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit(input int i);
    return hex_out[7*i +: 7];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic load(input logic [2:0] s, input logic [3:0] c);
    load_valid = 1'b1;
    load_slot  = s;
    load_card  = c;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(load_ready), 64'(1'b1));
  endtask

  task automatic check_idle_blank(input string name);
    check({name, "_hex"},   64'(hex_out),    64'(ALL_OFF));
    check({name, "_ready"}, 64'(load_ready), 64'(1'b1));
    check({name, "_busy"},  64'(busy),       64'(1'b0));
  endtask

  initial begin
    logic [41:0] masked;
    logic [6:0]  exp_d;
    int          waited;

    gv[0]  = '{4'd0,  7'b1111111};
    gv[1]  = '{4'd1,  7'b0001000};
    gv[2]  = '{4'd2,  7'b0100100};
    gv[3]  = '{4'd3,  7'b0110000};
    gv[4]  = '{4'd4,  7'b0011001};
    gv[5]  = '{4'd5,  7'b0010010};
    gv[6]  = '{4'd6,  7'b0000010};
    gv[7]  = '{4'd7,  7'b1111000};
    gv[8]  = '{4'd8,  7'b0000000};
    gv[9]  = '{4'd9,  7'b0010000};
    gv[10] = '{4'd10, 7'b1000000};
    gv[11] = '{4'd11, 7'b1100001};
    gv[12] = '{4'd12, 7'b0011000};
    gv[13] = '{4'd13, 7'b0001001};
    gv[14] = '{4'd14, 7'b1111111};
    gv[15] = '{4'd15, 7'b1111111};

    fv[0] = '{3'd0, 4'd10, 7'b1000000};
    fv[1] = '{3'd1, 4'd11, 7'b1100001};
    fv[2] = '{3'd2, 4'd12, 7'b0011000};
    fv[3] = '{3'd3, 4'd14, 7'b1111111};
    fv[4] = '{3'd4, 4'd15, 7'b1111111};
    fv[5] = '{3'd5, 4'd0,  7'b1111111};

    rst        = 1'b1;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_slot  = '0;
    load_card  = '0;
    #12;
    check_idle_blank("reset");
    rst = 1'b0;
    tick();

    // Glyph table on slot 0: blank in phase 0, glyph in phase 1, glyph once done.
    for (int v = 0; v < 16; v++) begin
      load(3'd0, gv[v].card);
      check($sformatf("glyph%0d_ph0", v), 64'(digit(0)), 64'(E));
      check($sformatf("glyph%0d_busy", v), 64'(busy), 64'(1'b1));
      ticks(4);
      check($sformatf("glyph%0d_ph1", v), 64'(digit(0)), 64'(gv[v].glyph));
      ticks(12);
      check($sformatf("glyph%0d_done", v), 64'(busy), 64'(1'b0));
      check($sformatf("glyph%0d_final", v), 64'(digit(0)), 64'(gv[v].glyph));
    end

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_blank("clear_idle");

    // King on slot 2: cycle-by-cycle blink pattern, other digits untouched.
    load(3'd2, 4'd13);
    for (int c = 1; c <= 16; c++) begin
      exp_d = (((c - 1) / 4) % 2 == 1) ? 7'b0001001 : E;
      check($sformatf("king_c%0d_d2", c), 64'(digit(2)), 64'(exp_d));
      check($sformatf("king_c%0d_busy", c), 64'(busy), 64'(1'b1));
      masked = hex_out;
      masked[20:14] = E;
      check($sformatf("king_c%0d_others", c), 64'(masked), 64'(ALL_OFF));
      tick();
    end
    check("king_end_busy", 64'(busy), 64'(1'b0));
    check("king_end_d2", 64'(digit(2)), 64'(7'b0001001));

    // Second load held off by busy, accepted once ready returns.
    load(3'd0, 4'd1);
    ticks(2);
    load_valid = 1'b1;
    load_slot  = 3'd1;
    load_card  = 4'd5;
    waited = 0;
    while (!load_ready && waited < 40) begin
      tick();
      waited++;
    end
    check("hold_wait_cycles", 64'(waited), 64'(14));
    check("hold_d1_unwritten", 64'(digit(1)), 64'(E));
    tick();
    load_valid = 1'b0;
    check("hold_accept_busy", 64'(busy), 64'(1'b1));
    check("hold_d1_ph0", 64'(digit(1)), 64'(E));
    check("hold_d0_ace", 64'(digit(0)), 64'(7'b0001000));
    ticks(4);
    check("hold_d1_ph1", 64'(digit(1)), 64'(7'b0010010));
    ticks(4);
    check("hold_d1_ph2", 64'(digit(1)), 64'(E));
    wait_ready("hold_ready_back");
    check("hold_d1_five", 64'(digit(1)), 64'(7'b0010010));
    check("hold_d0_final", 64'(digit(0)), 64'(7'b0001000));
    check("hold_d2_final", 64'(digit(2)), 64'(7'b0001001));

    // Clear at cycle 6 of a blink on slot 4.
    load(3'd4, 4'd7);
    ticks(5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_blank("clear_mid");

    // Clear wins over a simultaneous load.
    clear      = 1'b1;
    load_valid = 1'b1;
    load_slot  = 3'd3;
    load_card  = 4'd8;
    tick();
    clear      = 1'b0;
    load_valid = 1'b0;
    check_idle_blank("clear_vs_load");

    // Out-of-range slots are consumed silently.
    load(3'd6, 4'd9);
    check_idle_blank("oor6");
    load(3'd7, 4'd9);
    check_idle_blank("oor7");

    // Fill all slots, including the codes that render blank.
    for (int v = 0; v < 6; v++) begin
      load(fv[v].slot, fv[v].card);
      wait_ready($sformatf("fill%0d_ready", v));
    end
    for (int v = 0; v < 6; v++) begin
      check($sformatf("fill_d%0d", v), 64'(digit(v)), 64'(fv[v].glyph));
    end

    // Asynchronous reset in the middle of a blink.
    load(3'd3, 4'd3);
    ticks(5);
    check("arst_pre_busy", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    #1;
    check_idle_blank("arst");
    #2;
    rst = 1'b0;
    tick();
    check_idle_blank("arst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
